simple_dma_controller: RTL
==========================

Name: simple_dma_controller

Overview:
- Bus-master stage directly downstream of the simple DMA peripheral device. Takes its request (start address, word count, direction) and moves 16-bit words between system memory and that device.
- Memory access goes through the CPU core's DMA master port (word address `dma_addr[15:1]`, `dma_en`/`dma_ready` handshake).
- Each word is handshaked with the device via `dev_ack` (device ready) and `dma_ack` (word done). Completion is signalled on `dma_end_flag`.

Parameters:
- `TIMEOUT_CYC`, 16'd1024, max cycles spent waiting for `dev_ack` before abort (used only with `DMA_CTRL_TIMEOUT_EN`).
- `PRIORITY`, 1'b0, constant value driven on `dma_priority`.

Ports:
- `clk`  in  1  main system clock
- `reset_n`  in  1  reset, synchronous, active-low
- `dma_rqst`  in  1  transfer request from device (level)
- `dma_rd_wr`  in  1  1: memory→device (read), 0: device→memory (write)
- `dma_start_address`  in  16  byte start address; bit 0 ignored
- `dma_num_words`  in  16  words to transfer
- `dev_ack`  in  1  device ready for next word
- `dev_out`  in  16  write data from device
- `dev_in`  out  16  read data to device
- `dma_ack`  out  1  one-cycle pulse per completed word
- `dma_end_flag`  out  1  transfer finished
- `dma_err`  out  1  transfer aborted by timeout
- `dma_addr`  out  15  memory word address
- `dma_din`  out  16  memory write data
- `dma_en`  out  1  memory access request
- `dma_we`  out  2  byte write enables
- `dma_priority`  out  1  bus priority
- `dma_dout`  in  16  memory read data
- `dma_ready`  in  1  access accepted this cycle
- `dma_resp`  in  1  bus error response (ignored in this revision)

Behaviour:
- Reset: all actions on the `clk` rising edge when `reset_n`=0. FSM goes to IDLE. `dev_in`, `dma_addr`, `dma_din`, `dma_we`=0; `dma_en`, `dma_ack`, `dma_end_flag`, `dma_err`=0. Counters cleared. Reset mid-transfer abandons the transfer immediately, with no `dma_end_flag`.
- `dma_priority` = `PRIORITY` at all times.
- State machine:
  - IDLE: when `dma_rqst`=1, latch `addr` = `dma_start_address[15:1]`, `cnt` = `dma_num_words`, `dir` = `dma_rd_wr`. If `dma_num_words`=0 go to DONE, else go to WAIT_DEV.
  - WAIT_DEV: wait for `dev_ack`=1.
    - Write (`dir`=0): capture `dev_out` into `dma_din` in the same cycle `dev_ack` is seen. A single-cycle `dev_ack` pulse is sufficient.
    - Then go to BUS.
  - BUS: drive `dma_en`=1, `dma_addr`=`addr`; `dma_we`=2'b11 for write, 2'b00 for read. Hold until `dma_ready`=1. Next state is RD_DATA for read, ACK for write.
  - RD_DATA: `dma_en`=0; register `dma_dout` into `dev_in` (data is valid the cycle after acceptance). Go to ACK.
  - ACK:
    - `dma_ack`=1 for exactly one cycle; `dev_in` is stable during it.
    - `addr`<=`addr`+1, wrapping 0x7FFF→0x0000; `cnt`<=`cnt`-1.
    - If new `cnt`=0 go to DONE, else go to WAIT_DEV.
  - DONE: `dma_end_flag`=1, held until `dma_rqst`=0; then return to IDLE with the flag cleared next cycle. A new transfer needs `dma_rqst` to be low for at least one cycle.
- Read latency per word (`dev_ack` already high, `dma_ready` immediate): WAIT_DEV→BUS→RD_DATA→ACK gives `dma_ack` 3 cycles after leaving WAIT_DEV.
- Write latency per word: `dma_ack` 2 cycles after `dev_ack` is sampled.
- `dma_rqst` falls mid-transfer:
  - In WAIT_DEV: go to IDLE next cycle, no `dma_ack`, no end flag.
  - In BUS/RD_DATA/ACK: finish the current word including `dma_ack`, then go to IDLE. No end flag.
- `dma_ack` is never asserted outside ACK. `dma_en` is never asserted outside BUS.
- `dma_rd_wr`, `dma_start_address` and `dma_num_words` changing mid-transfer have no effect (latched copies are used).

Optional Feature:
- `DMA_CTRL_TIMEOUT_EN` defined:
  - A 16-bit counter runs while in WAIT_DEV and resets on entry.
  - On reaching `TIMEOUT_CYC` without `dev_ack`: go to DONE with `dma_err`=1.
  - `dma_err` stays high until the next IDLE→WAIT_DEV/DONE start.
- Not defined: WAIT_DEV waits indefinitely; `dma_err` is tied to 0; no counter is synthesized.

Test Plan:
- Read 3 words, start 0x0200, mem[0x0200..0x0204]=0x1111/0x2222/0x3333, `dev_ack`=1, `dma_ready`=1 → three `dma_ack` pulses with `dev_in`=0x1111, 0x2222, 0x3333; `dma_addr`=0x100, 0x101, 0x102; then `dma_end_flag`=1 until `dma_rqst` drops.
- Write 2 words at 0x0300, `dev_ack` pulsed one cycle with `dev_out`=0xABCD, then 0x1234; `dma_ready` delayed 2 cycles → `dma_en` held 3 cycles each; memory gets 0xABCD@0x0300 and 0x1234@0x0302; 2 `dma_ack` pulses.
- `dma_num_words`=0, `dma_rqst`=1 → `dma_end_flag`=1 next cycle; no `dma_en`, no `dma_ack`.
- Read 2 words from 0xFFFE → `dma_addr`=0x7FFF, then 0x0000.
- 4-word read, `dma_rqst` dropped during second BUS → second `dma_ack` still pulses, FSM returns to IDLE, `dma_end_flag` stays 0. `reset_n`=0 mid-BUS → `dma_en`=0 after that edge.
- With `DMA_CTRL_TIMEOUT_EN`, `TIMEOUT_CYC`=8, `dev_ack` held 0 → `dma_err`=1 and `dma_end_flag`=1 after 8 WAIT_DEV cycles; without the macro → still waiting after 100 cycles, `dma_err`=0.

Source files
------------

// File: rtl/simple_dma_controller.sv
// Bus-master DMA stage: moves 16-bit words between memory and the DMA device.
// Define DMA_CTRL_TIMEOUT_EN to abort transfers whose device stalls in WAIT_DEV.
module simple_dma_controller #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd1024,
    parameter logic        PRIORITY    = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_err,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DEV, S_BUS, S_RD_DATA, S_ACK, S_DONE
    } state_t;

    state_t      state;
    logic [14:0] addr;
    logic [15:0] cnt;
    logic [15:0] cnt_dec;
    logic        dir;
    logic        abort;
    logic        unused_inputs;

    assign cnt_dec       = cnt - 16'd1;
    assign dma_priority  = PRIORITY;
    assign unused_inputs = ^{dma_resp, dma_start_address[0], TIMEOUT_CYC};

`ifdef DMA_CTRL_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_hit;
    assign to_hit = (to_cnt == TIMEOUT_CYC - 16'd1);
`else
    assign dma_err = 1'b0;
`endif

    // Memory handshake: dma_en is held with a stable address/data until
    // dma_ready is 1; the word moves on the edge where both are 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            addr         <= 15'd0;
            cnt          <= 16'd0;
            dir          <= 1'b0;
            abort        <= 1'b0;
            dev_in       <= 16'd0;
            dma_addr     <= 15'd0;
            dma_din      <= 16'd0;
            dma_we       <= 2'b00;
            dma_en       <= 1'b0;
            dma_ack      <= 1'b0;
            dma_end_flag <= 1'b0;
`ifdef DMA_CTRL_TIMEOUT_EN
            dma_err      <= 1'b0;
            to_cnt       <= 16'd0;
`endif
        end else begin
            dma_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dma_rqst) begin
                        addr  <= dma_start_address[15:1];
                        cnt   <= dma_num_words;
                        dir   <= dma_rd_wr;
                        abort <= 1'b0;
`ifdef DMA_CTRL_TIMEOUT_EN
                        dma_err <= 1'b0;
                        to_cnt  <= 16'd0;
`endif
                        if (dma_num_words == 16'd0) begin
                            state        <= S_DONE;
                            dma_end_flag <= 1'b1;
                        end else begin
                            state <= S_WAIT_DEV;
                        end
                    end
                end
                S_WAIT_DEV: begin
                    if (!dma_rqst) begin
                        state <= S_IDLE;
                    end else if (dev_ack) begin
                        if (!dir) dma_din <= dev_out;
                        dma_en   <= 1'b1;
                        dma_addr <= addr;
                        dma_we   <= dir ? 2'b00 : 2'b11;
                        state    <= S_BUS;
                    end
`ifdef DMA_CTRL_TIMEOUT_EN
                    else if (to_hit) begin
                        state        <= S_DONE;
                        dma_end_flag <= 1'b1;
                        dma_err      <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                S_BUS: begin
                    // A dropped request only takes effect once this word is acked.
                    if (!dma_rqst) abort <= 1'b1;
                    if (dma_ready) begin
                        dma_en <= 1'b0;
                        dma_we <= 2'b00;
                        if (dir) begin
                            state <= S_RD_DATA;
                        end else begin
                            state   <= S_ACK;
                            dma_ack <= 1'b1;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (!dma_rqst) abort <= 1'b1;
                    dev_in  <= dma_dout;
                    dma_ack <= 1'b1;
                    state   <= S_ACK;
                end
                S_ACK: begin
                    addr <= addr + 15'd1;
                    cnt  <= cnt_dec;
`ifdef DMA_CTRL_TIMEOUT_EN
                    to_cnt <= 16'd0;
`endif
                    if (abort || !dma_rqst) begin
                        state <= S_IDLE;
                    end else if (cnt_dec == 16'd0) begin
                        state        <= S_DONE;
                        dma_end_flag <= 1'b1;
                    end else begin
                        state <= S_WAIT_DEV;
                    end
                end
                S_DONE: begin
                    if (!dma_rqst) begin
                        dma_end_flag <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
